// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared frame geometry, capture FSM encoding and colour-bar lookup.
package cam_pkg;

  localparam int CAM_X    = 160;
  localparam int CAM_Y    = 120;
  localparam int AW       = 15;
  localparam int DW       = 12;
  localparam int IMG_SIZE = CAM_X * CAM_Y;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
    logic [11:0] rgb;
    case (idx)
      3'd0:    rgb = 12'hFFF;
      3'd1:    rgb = 12'hFF0;
      3'd2:    rgb = 12'h0FF;
      3'd3:    rgb = 12'h0F0;
      3'd4:    rgb = 12'hF0F;
      3'd5:    rgb = 12'hF00;
      3'd6:    rgb = 12'h00F;
      default: rgb = 12'h000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/edge_det.sv
// rtl/edge_det.sv - registered copy of a level input with rise/fall strobes.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) d_q <= 1'b0;
    else      d_q <= d;
  end

  assign rise = ~d_q & d;
  assign fall = d_q & ~d;

endmodule

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - VSYNC-aligned frame capture sequencer driving the frame buffer write port.
// Optional CAPTURE_TEST_PATTERN_EN adds tp_sel, replacing pixel data with eight vertical colour bars.
module capture_ctrl #(
  parameter int CAM_X = cam_pkg::CAM_X,
  parameter int CAM_Y = cam_pkg::CAM_Y,
  parameter int AW    = cam_pkg::AW,
  parameter int DW    = cam_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cont_en,
  input  logic          abort,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic          px_valid,
`ifdef CAPTURE_TEST_PATTERN_EN
  input  logic          tp_sel,
`endif
  input  logic [DW-1:0] px_data,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          busy,
  output logic          frame_done,
  output logic          frame_err,
  output logic [7:0]    frame_cnt
);

  import cam_pkg::*;

  localparam int              LW    = $clog2(CAM_Y) + 1;
  localparam logic [AW-1:0]   IMG_A = AW'(CAM_X * CAM_Y);
  localparam logic [LW-1:0]   LINES = LW'(CAM_Y);
  localparam logic [LW-1:0]   L_MAX = '1;

  state_e          state_q, state_d;
  logic [AW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [LW-1:0]   line_cnt_q, line_cnt_d;
  logic            frame_err_q, frame_err_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic            ram_we_q, ram_we_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [DW-1:0]   ram_data_q, ram_data_d;
  logic [DW-1:0]   pix_word;
  logic            vs_rise, vs_fall, href_fall, href_rise_unused;

  edge_det u_vsync_det (
    .clk  (clk),
    .rst  (rst),
    .d    (cam_vsync),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  edge_det u_href_det (
    .clk  (clk),
    .rst  (rst),
    .d    (cam_href),
    .rise (href_rise_unused),
    .fall (href_fall)
  );

`ifdef CAPTURE_TEST_PATTERN_EN
  logic [AW-1:0] col;
  logic [AW-1:0] bar;
  always_comb begin
    col      = pix_cnt_q % AW'(CAM_X);
    bar      = col / AW'(CAM_X / 8);
    pix_word = tp_sel ? DW'(bar_rgb(bar[2:0])) : px_data;
  end
`else
  assign pix_word = px_data;
`endif

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    frame_err_d = frame_err_q;
    frame_cnt_d = frame_cnt_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d     = ARM;
            frame_err_d = 1'b0;
          end
        end
        ARM: begin
          // Waiting for a fresh VSYNC fall skips any frame already underway.
          if (vs_fall) begin
            state_d    = CAPTURE;
            pix_cnt_d  = '0;
            line_cnt_d = '0;
          end
        end
        CAPTURE: begin
          if (px_valid) begin
            if (pix_cnt_q < IMG_A) begin
              ram_we_d   = 1'b1;
              ram_addr_d = pix_cnt_q;
              ram_data_d = pix_word;
              pix_cnt_d  = pix_cnt_q + 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end
          if (href_fall && line_cnt_q != L_MAX) line_cnt_d = line_cnt_q + 1'b1;
          // Geometry check uses the next-state counts so a coincident last pixel/line is included.
          if (vs_rise) begin
            if (pix_cnt_d != IMG_A || line_cnt_d != LINES) frame_err_d = 1'b1;
            state_d = DONE;
          end
        end
        DONE: begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          state_d     = cont_en ? ARM : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE) && !abort;
  assign frame_err  = frame_err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
